// File: rtl/mc_pkg.sv
// ============================================================================
// mc_pkg : shared state, PC-select and op-bit encodings for the sequencer
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd7
  } state_e;

  localparam logic [1:0] PCSEL_PC4 = 2'd0;
  localparam logic [1:0] PCSEL_BR  = 2'd1;
  localparam logic [1:0] PCSEL_J   = 2'd2;
  localparam logic [1:0] PCSEL_JR  = 2'd3;

  localparam int OP_W    = 9;
  localparam int OP_ADDU = 0;
  localparam int OP_SUBU = 1;
  localparam int OP_ORI  = 2;
  localparam int OP_LW   = 3;
  localparam int OP_SW   = 4;
  localparam int OP_BEQ  = 5;
  localparam int OP_LUI  = 6;
  localparam int OP_JAL  = 7;
  localparam int OP_JR   = 8;

  function automatic logic is_onehot(input logic [OP_W-1:0] v);
    return (v != '0) && ((v & (v - OP_W'(1))) == '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_seq_decode.sv
// ============================================================================
// mc_seq_decode : per-state strobe and next-state mapping (purely combinational)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mc_seq_decode
  import mc_pkg::*;
(
  input  state_e          state,
  input  logic [OP_W-1:0] op,
  input  logic            equal,
  input  logic            mem_ready,
  output state_e          next_state,
  output logic            set_illegal,
  output logic            mem_req,
  output logic            mem_is_data,
  output logic            mem_we,
  output logic            ir_write,
  output logic            pc_write,
  output logic [1:0]      pc_sel,
  output logic            grf_write,
  output logic            retire
);

  always_comb begin
    next_state  = state;
    set_illegal = 1'b0;
    mem_req     = 1'b0;
    mem_is_data = 1'b0;
    mem_we      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_sel      = PCSEL_PC4;
    grf_write   = 1'b0;
    retire      = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!is_onehot(op)) begin
          set_illegal = 1'b1;
          next_state  = ST_HALT;
        end else if (op[OP_JAL]) begin
          // PC already holds PC+4 from FETCH, so ra is written from PC here
          grf_write  = 1'b1;
          pc_write   = 1'b1;
          pc_sel     = PCSEL_J;
          retire     = 1'b1;
          next_state = ST_FETCH;
        end else if (op[OP_JR]) begin
          pc_write   = 1'b1;
          pc_sel     = PCSEL_JR;
          retire     = 1'b1;
          next_state = ST_FETCH;
        end else begin
          next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (op[OP_BEQ]) begin
          pc_write   = equal;
          pc_sel     = PCSEL_BR;
          retire     = 1'b1;
          next_state = ST_FETCH;
        end else if (op[OP_LW] || op[OP_SW]) begin
          next_state = ST_MEM;
        end else begin
          next_state = ST_WB;
        end
      end
      ST_MEM: begin
        mem_req     = 1'b1;
        mem_is_data = 1'b1;
        mem_we      = op[OP_SW];
        if (mem_ready) begin
          if (op[OP_SW]) begin
            retire     = 1'b1;
            next_state = ST_FETCH;
          end else begin
            next_state = ST_WB;
          end
        end
      end
      ST_WB: begin
        grf_write  = 1'b1;
        retire     = 1'b1;
        next_state = ST_FETCH;
      end
      default: next_state = ST_HALT;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_sequencer.sv
// ============================================================================
// mc_sequencer : multi-cycle FETCH/DECODE/EXEC/MEM/WB control for the MIPS core
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mc_sequencer
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [8:0]       op,
  input  logic             equal,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             mem_req,
  output logic             mem_is_data,
  output logic             mem_we,
  output logic             IR_write,
  output logic             PC_write,
  output logic [1:0]       PC_sel,
  output logic             GRF_write,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_count
);

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q, count_d;

  state_e     w_next_state;
  logic       w_set_illegal;
  logic       w_mem_req, w_mem_is_data, w_mem_we;
  logic       w_ir_write, w_pc_write, w_grf_write, w_retire;
  logic [1:0] w_pc_sel;

  mc_seq_decode u_decode (
    .state       (state_q),
    .op          (op),
    .equal       (equal),
    .mem_ready   (mem_ready),
    .next_state  (w_next_state),
    .set_illegal (w_set_illegal),
    .mem_req     (w_mem_req),
    .mem_is_data (w_mem_is_data),
    .mem_we      (w_mem_we),
    .ir_write    (w_ir_write),
    .pc_write    (w_pc_write),
    .pc_sel      (w_pc_sel),
    .grf_write   (w_grf_write),
    .retire      (w_retire)
  );

  always_comb begin
    state_d   = w_next_state;
    illegal_d = illegal_q | w_set_illegal;
    count_d   = w_retire ? count_q + CNT_W'(1) : count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  // Reset kills every side-effecting strobe, including an in-flight request
  assign mem_req       = w_mem_req   & ~reset;
  assign mem_is_data   = w_mem_is_data;
  assign mem_we        = w_mem_we    & ~reset;
  assign IR_write      = w_ir_write  & ~reset;
  assign PC_write      = w_pc_write  & ~reset;
  assign PC_sel        = w_pc_sel;
  assign GRF_write     = w_grf_write & ~reset;
  assign retire        = w_retire    & ~reset;
  assign state         = state_q;
  assign illegal       = illegal_q;
  assign retired_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_sequencer.sv
// ============================================================================
// tb_mc_sequencer : directed checks of the sequencer with a 4-bit retire counter
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_mc_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] op;
  logic       equal;
  logic       mem_ready;
  logic [2:0] state;
  logic       mem_req, mem_is_data, mem_we, IR_write, PC_write, GRF_write, retire, illegal;
  logic [1:0] PC_sel;
  logic [3:0] retired_count;

  int n_chk  = 0;
  int n_fail = 0;

  mc_sequencer #(.CNT_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .op            (op),
    .equal         (equal),
    .mem_ready     (mem_ready),
    .state         (state),
    .mem_req       (mem_req),
    .mem_is_data   (mem_is_data),
    .mem_we        (mem_we),
    .IR_write      (IR_write),
    .PC_write      (PC_write),
    .PC_sel        (PC_sel),
    .GRF_write     (GRF_write),
    .retire        (retire),
    .illegal       (illegal),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] strobes();
    return {mem_req, mem_is_data, mem_we, IR_write, PC_write, GRF_write, retire};
  endfunction

  initial begin
    reset = 1'b1; op = 9'h000; equal = 1'b0; mem_ready = 1'b0;
    cyc(); cyc();
    mem_ready = 1'b1; #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ir_write", IR_write, 0);
    chk("rst_pc_write", PC_write, 0);
    reset = 1'b0; #1;
    chk("rst_state", state, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_count", retired_count, 0);

    // addu, zero-wait memory
    op = 9'h001; #1;
    chk("addu_f_req", mem_req, 1);
    chk("addu_f_isdata", mem_is_data, 0);
    chk("addu_f_ir", IR_write, 1);
    chk("addu_f_pcw", PC_write, 1);
    chk("addu_f_pcsel", PC_sel, 0);
    cyc(); chk("addu_d_state", state, 1); chk("addu_d_ir", IR_write, 0); chk("addu_d_grf", GRF_write, 0);
    cyc(); chk("addu_e_state", state, 2); chk("addu_e_retire", retire, 0);
    cyc(); chk("addu_w_state", state, 4); chk("addu_w_grf", GRF_write, 1); chk("addu_w_retire", retire, 1);
    cyc(); chk("addu_done_state", state, 0); chk("addu_count", retired_count, 1);

    // lw with three wait cycles in MEM
    op = 9'h008; #1;
    chk("lw_f_ir", IR_write, 1);
    cyc(); chk("lw_d_state", state, 1);
    cyc(); chk("lw_e_state", state, 2);
    for (int i = 0; i < 3; i++) begin
      cyc(); mem_ready = 1'b0; #1;
      chk("lw_wait_state", state, 3);
      chk("lw_wait_req", mem_req, 1);
      chk("lw_wait_isdata", mem_is_data, 1);
      chk("lw_wait_we", mem_we, 0);
    end
    cyc(); mem_ready = 1'b1; #1;
    chk("lw_mem_state", state, 3); chk("lw_mem_we", mem_we, 0); chk("lw_mem_retire", retire, 0);
    cyc(); chk("lw_wb_state", state, 4); chk("lw_wb_grf", GRF_write, 1); chk("lw_wb_retire", retire, 1);
    cyc(); chk("lw_done_state", state, 0); chk("lw_count", retired_count, 2);

    // beq taken then not taken
    op = 9'h020; equal = 1'b1;
    cyc(); cyc();
    chk("beq1_state", state, 2); chk("beq1_pcw", PC_write, 1); chk("beq1_pcsel", PC_sel, 1);
    chk("beq1_retire", retire, 1);
    cyc(); chk("beq1_done", state, 0); chk("beq1_count", retired_count, 3);
    equal = 1'b0;
    cyc(); cyc();
    chk("beq0_state", state, 2); chk("beq0_pcw", PC_write, 0); chk("beq0_retire", retire, 1);
    cyc(); chk("beq0_done", state, 0); chk("beq0_count", retired_count, 4);

    // jal then jr
    op = 9'h080;
    cyc();
    chk("jal_state", state, 1); chk("jal_grf", GRF_write, 1); chk("jal_pcw", PC_write, 1);
    chk("jal_pcsel", PC_sel, 2); chk("jal_retire", retire, 1);
    cyc(); chk("jal_done", state, 0); chk("jal_count", retired_count, 5);
    op = 9'h100;
    cyc();
    chk("jr_state", state, 1); chk("jr_grf", GRF_write, 0); chk("jr_pcw", PC_write, 1);
    chk("jr_pcsel", PC_sel, 3); chk("jr_retire", retire, 1);
    cyc(); chk("jr_done", state, 0); chk("jr_count", retired_count, 6);

    // op=0 is illegal and halts
    op = 9'h000;
    cyc(); chk("ill_d_retire", retire, 0);
    cyc(); chk("ill_state", state, 7); chk("ill_flag", illegal, 1);
    for (int i = 0; i < 10; i++) begin
      chk("halt_strobes", strobes(), 0);
      chk("halt_state", state, 7);
      cyc();
    end
    reset = 1'b1;
    cyc(); reset = 1'b0; #1;
    chk("ill_rst_state", state, 0); chk("ill_rst_flag", illegal, 0); chk("ill_rst_count", retired_count, 0);

    // multi-hot op is also illegal
    op = 9'h003;
    cyc(); cyc();
    chk("multi_state", state, 7); chk("multi_flag", illegal, 1);
    reset = 1'b1;
    cyc(); reset = 1'b0; #1;
    chk("multi_rst_state", state, 0);

    // 16 sw, counter wraps through 15 to 0
    op = 9'h010;
    for (int i = 0; i < 16; i++) begin
      cyc(); cyc(); cyc();
      chk("sw_state", state, 3); chk("sw_we", mem_we, 1); chk("sw_isdata", mem_is_data, 1);
      chk("sw_retire", retire, 1);
      cyc();
      if (i == 14) chk("sw_count15", retired_count, 15);
    end
    chk("sw_wrap_count", retired_count, 0);
    chk("sw_wrap_state", state, 0);

    // reset during a pending data request
    cyc(); cyc(); cyc();
    mem_ready = 1'b0; #1;
    chk("rmem_state", state, 3); chk("rmem_req_before", mem_req, 1);
    reset = 1'b1; #1;
    chk("rmem_req", mem_req, 0); chk("rmem_we", mem_we, 0);
    cyc(); reset = 1'b0; #1;
    chk("rmem_after_state", state, 0);
    cyc(); chk("rmem_fetch_state", state, 0); chk("rmem_fetch_req", mem_req, 1);
    chk("rmem_fetch_ir", IR_write, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mc_sequencer.md
# mc_sequencer

Multi-cycle sequencer for the MIPS-subset core (addu, subu, ori, lw, sw, beq, lui, jal, jr). Sits between the instruction-class decoder and the shared datapath (single memory port, GRF, ALU, PC). It steps each instruction through FETCH/DECODE/EXEC/MEM/WB, issues per-state write strobes and memory requests, and handles a variable-latency memory handshake. It also counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, retired-instruction counter width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- op  in  9  one-hot instruction class from decoder: bit0 addu, 1 subu, 2 ori, 3 lw, 4 sw, 5 beq, 6 lui, 7 jal, 8 jr
- equal  in  1  ALU rs==rt compare, valid in EXEC
- mem_ready  in  1  memory completes current request this cycle
- state  out  3  current state code
- mem_req  out  1  memory request active
- mem_is_data  out  1  1 = data access, 0 = instruction fetch
- mem_we  out  1  data write (sw)
- IR_write  out  1  latch instruction register
- PC_write  out  1  update PC
- PC_sel  out  2  0 PC+4, 1 branch target, 2 jal target, 3 rs (jr)
- GRF_write  out  1  register file write enable
- retire  out  1  one-cycle pulse on instruction completion
- illegal  out  1  sticky; op not one-hot
- retired_count  out  CNT_W  retired instructions, wraps

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7. Strobes are combinational from state, op, equal and mem_ready.
- FETCH: mem_req=1, mem_is_data=0. Hold until mem_ready. In that cycle: IR_write=1, PC_write=1, PC_sel=0; go to DECODE.
- DECODE: op zero or multi-hot -> illegal<=1, go to HALT. jal -> GRF_write=1 (ra<=PC, which already holds PC+4), PC_write=1, PC_sel=2, retire, go to FETCH. jr -> PC_write=1, PC_sel=3, retire, go to FETCH. Otherwise go to EXEC.
- EXEC: beq -> PC_write=equal, PC_sel=1, retire, go to FETCH. lw/sw -> go to MEM. addu/subu/ori/lui -> go to WB.
- MEM: mem_req=1, mem_is_data=1, mem_we=op[4]. Hold until mem_ready. On mem_ready: sw retires and goes to FETCH; lw goes to WB.
- WB: GRF_write=1, retire, go to FETCH.
- HALT: all strobes 0. Held until reset.
- retired_count increments on every retire and wraps from 2^CNT_W-1 to 0.
- mem_ready is ignored when mem_req=0.
- op is sampled in every state. It stays stable because IR_write fires only in FETCH.

## Timing
- Reset: state=FETCH, illegal=0, retired_count=0. While reset is high every strobe (mem_req, IR_write, PC_write, GRF_write, mem_we, retire) is forced to 0.
- Cycles per instruction with zero-wait memory: jal/jr 2, beq 3, addu/subu/ori/lui/sw 4, lw 5. Each wait cycle on mem_ready adds 1 cycle in FETCH or MEM.
- retire and the final PC_write/GRF_write fall in the same cycle. The new state is visible the next cycle.
- Reset asserted mid-request: mem_req drops in that cycle and FETCH begins after reset deasserts. An abandoned memory request is the memory's responsibility.
- mem_ready held high continuously: one transfer per FETCH or MEM visit; no double IR_write.

## Structure
- Shared package mc_pkg holds: state codes, PC_sel codes (PCSEL_PC4/BR/J/JR), op bit indices (OP_ADDU..OP_JR).
- Sub-module mc_seq_decode: combinational mapping of state, op, equal, mem_ready to the strobe set. The top holds the state register, the illegal flag and the counter.

## Test plan
- Reset, then addu with mem_ready tied 1: states 0,1,2,4,0; GRF_write only in cycle 4; retire once; retired_count=1.
- lw with mem_ready low for 3 cycles in MEM: 8 cycles total; mem_is_data=1 and mem_we=0 throughout MEM; GRF_write in WB.
- beq with equal=1 then equal=0: PC_write=1, PC_sel=1 on the first; PC_write=0 on the second; both retire after 3 cycles.
- jal then jr: each takes 2 cycles; jal has GRF_write=1 and PC_sel=2; jr has PC_sel=3; retired_count=2.
- op=0 in DECODE: illegal=1, state=7, all strobes stay 0 for 10 cycles. Reset clears illegal and returns to FETCH.
- Preload counter path (CNT_W=4), run 16 sw: count wraps to 0. Reset asserted during MEM: mem_req=0 that cycle; state=0 after deassert.
